// File: rtl/mdu_ctrl_pkg.sv
// Shared types and constants for the multiply/divide unit arbiter.
package mdu_ctrl_pkg;

  localparam int OP_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mdu_arbiter_rr_arbiter.sv
// Round-robin pointer search: first requester above last_grant, wrapping around.
module rr_arbiter
  import mdu_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_valid
);

  int cand_s;

  // Priority search starting one past the previous winner.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_s      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = (int'(last_grant) + k) % NREQ;
      if (!grant_valid && req[cand_s]) begin
        grant[cand_s] = 1'b1;
        grant_idx     = IDW'(cand_s);
        grant_valid   = 1'b1;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/mdu_arbiter.sv
// Shares one multiply/divide unit between NREQ requesters: round-robin accept,
// one-cycle launch, completion wait with optional watchdog, valid/ready response.
module mdu_arbiter
  import mdu_ctrl_pkg::*;
#(
  parameter int   PARALLELISM = 32,
  parameter int   NREQ        = 2,
  parameter int   TIMEOUT     = 1024,
  localparam int  IDW         = id_width(NREQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [OP_W*NREQ-1:0]        req_op_code,
  input  logic [PARALLELISM*NREQ-1:0] req_lop,
  input  logic [PARALLELISM*NREQ-1:0] req_rop,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [IDW-1:0]              resp_id,
  output logic [PARALLELISM-1:0]      resp_result,
  output logic                        resp_div_by_zero,
  output logic                        resp_div_overflow,
  output logic                        resp_timeout,
  output logic                        mdu_valid,
  output logic [OP_W-1:0]             mdu_op_code,
  output logic [PARALLELISM-1:0]      mdu_lop,
  output logic [PARALLELISM-1:0]      mdu_rop,
  input  logic [PARALLELISM-1:0]      mdu_result,
  input  logic                        mdu_done,
  input  logic                        mdu_div_by_zero,
  input  logic                        mdu_div_overflow,
  output logic                        busy,
  output logic                        fault
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e                 state_q, state_d;
  logic [IDW-1:0]         last_q, last_d, id_q, id_d;
  logic [OP_W-1:0]        op_q, op_d;
  logic [PARALLELISM-1:0] lop_q, lop_d, rop_q, rop_d, res_q, res_d;
  logic                   dbz_q, dbz_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NREQ-1:0]        grant_s;
  logic [IDW-1:0]         grant_idx_s;
  logic                   grant_valid_s;
  logic                   accept_s;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req         (req_valid),
    .last_grant  (last_q),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // Accept is only offered while idle and out of reset.
  assign accept_s  = (state_q == ST_IDLE) && grant_valid_s && !rst;
  assign req_ready = accept_s ? grant_s : '0;

  // Next-state, capture and watchdog logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    op_d    = op_q;
    lop_d   = lop_q;
    rop_d   = rop_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d    = req_op_code[grant_idx_s*OP_W +: OP_W];
          lop_d   = req_lop[grant_idx_s*PARALLELISM +: PARALLELISM];
          rop_d   = req_rop[grant_idx_s*PARALLELISM +: PARALLELISM];
          id_d    = grant_idx_s;
          last_d  = grant_idx_s;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mdu_done) begin
          res_d   = mdu_result;
          dbz_d   = mdu_div_by_zero;
          ovf_d   = mdu_div_overflow;
          tmo_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // A TIMEOUT of 0 leaves the counter free-running and never fires.
          if ((TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT))) begin
            res_d   = '0;
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
            tmo_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = tmo_q ? ST_FAULT : ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      op_q    <= '0;
      lop_q   <= '0;
      rop_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      lop_q   <= lop_d;
      rop_q   <= rop_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign resp_valid        = (state_q == ST_RESP);
  assign resp_id           = id_q;
  assign resp_result       = res_q;
  assign resp_div_by_zero  = dbz_q;
  assign resp_div_overflow = ovf_q;
  assign resp_timeout      = tmo_q;
  assign mdu_valid         = (state_q == ST_ISSUE);
  assign mdu_op_code       = op_q;
  assign mdu_lop           = lop_q;
  assign mdu_rop           = rop_q;
  assign busy              = (state_q != ST_IDLE);
  assign fault             = (state_q == ST_FAULT);

endmodule

// File: tb/tb_mdu_arbiter.sv
// Directed plus randomized bench for mdu_arbiter with a behavioural unit model
// and a transaction-level reference for grant order, latency and response.
module tb_mdu_arbiter;

  localparam int P   = 32;
  localparam int N   = 2;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [3*N-1:0]  req_op_code;
  logic [P*N-1:0]  req_lop, req_rop;
  logic            resp_valid, resp_ready;
  logic [0:0]      resp_id;
  logic [P-1:0]    resp_result;
  logic            resp_div_by_zero, resp_div_overflow, resp_timeout;
  logic            mdu_valid;
  logic [2:0]      mdu_op_code;
  logic [P-1:0]    mdu_lop, mdu_rop, mdu_result;
  logic            mdu_done, mdu_div_by_zero, mdu_div_overflow;
  logic            busy, fault;

  mdu_arbiter #(.PARALLELISM(P), .NREQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op_code(req_op_code),
    .req_lop(req_lop), .req_rop(req_rop),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_div_by_zero(resp_div_by_zero),
    .resp_div_overflow(resp_div_overflow), .resp_timeout(resp_timeout),
    .mdu_valid(mdu_valid), .mdu_op_code(mdu_op_code), .mdu_lop(mdu_lop),
    .mdu_rop(mdu_rop), .mdu_result(mdu_result), .mdu_done(mdu_done),
    .mdu_div_by_zero(mdu_div_by_zero), .mdu_div_overflow(mdu_div_overflow),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         ref_last;
  int         unit_lat = 1;
  bit         unit_hang = 1'b0;
  bit         stray = 1'b0;
  logic [2:0] op_a [N];
  logic [P-1:0] lop_a [N];
  logic [P-1:0] rop_a [N];

  // Unit behaviour: {overflow, div_by_zero, result}
  function automatic logic [P+1:0] unit_fn(input logic [2:0] op, input logic [P-1:0] a, input logic [P-1:0] b);
    if (op[2]) begin
      if (b == 32'd0) return {1'b0, 1'b1, 32'hFFFF_FFFF};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 1'b0, 32'h8000_0000};
      return {2'b00, a / b};
    end
    if (op[0]) return {2'b00, a + b};
    return {2'b00, a * b};
  endfunction

  // Unit model: done pulse unit_lat cycles after launch; noise on result/flags otherwise.
  initial begin : unit_model
    int hold;
    logic [P+1:0] pend;
    hold = 0;
    pend = '0;
    mdu_done = 1'b0; mdu_result = '0; mdu_div_by_zero = 1'b0; mdu_div_overflow = 1'b0;
    forever begin
      @(posedge clk); #1;
      mdu_done = 1'b0;
      mdu_result = $urandom;
      mdu_div_by_zero = 1'($urandom);
      mdu_div_overflow = 1'($urandom);
      if (stray) begin
        stray = 1'b0;
        mdu_done = 1'b1;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          mdu_done = 1'b1;
          {mdu_div_overflow, mdu_div_by_zero, mdu_result} = pend;
        end
      end
      if (mdu_valid === 1'b1 && !unit_hang) begin
        hold = unit_lat;
        pend = unit_fn(mdu_op_code, mdu_lop, mdu_rop);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) begin
      req_op_code[i*3 +: 3] = op_a[i];
      req_lop[i*P +: P]     = lop_a[i];
      req_rop[i*P +: P]     = rop_a[i];
    end
  endtask

  // Winner is the valid requester at the smallest forward distance past the last grant.
  function automatic int ref_pick(input logic [N-1:0] mask);
    int best, best_d, d;
    best = -1;
    best_d = N + 1;
    for (int i = 0; i < N; i++) begin
      d = (i - ref_last - 1 + 2 * N) % N;
      if (mask[i] && d < best_d) begin
        best = i;
        best_d = d;
      end
    end
    return best;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '1;
    resp_ready = 1'b0;
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_resp", {resp_valid, resp_id, resp_div_by_zero, resp_div_overflow, resp_timeout}, 0);
    check("rst_result", resp_result, 0);
    check("rst_ctl", {mdu_valid, mdu_op_code, busy, fault}, 0);
    check("rst_operands", {mdu_lop, mdu_rop}, 0);
    req_valid = '0;
    tick();
    rst = 1'b0;
    ref_last = N - 1;
  endtask

  task automatic transact(input logic [N-1:0] add, input int lat, input int bp, input bit hang);
    int pick, n, launches;
    logic [N-1:0] exp_ready;
    logic [P+1:0] e;
    logic eto;
    unit_lat = lat;
    unit_hang = hang;
    req_valid = req_valid | add;
    drive_data();
    #1;
    pick = ref_pick(req_valid);
    if (pick < 0) pick = 0;
    exp_ready = '0;
    exp_ready[pick] = 1'b1;
    check("req_ready_grant", req_ready, exp_ready);
    e = hang ? '0 : unit_fn(op_a[pick], lop_a[pick], rop_a[pick]);
    eto = hang;
    ref_last = pick;
    tick();
    req_valid[pick] = 1'b0;
    check("launch", {mdu_valid, busy}, 2'b11);
    check("launch_ops", {mdu_op_code, mdu_lop, mdu_rop}, {op_a[pick], lop_a[pick], rop_a[pick]});
    n = 0;
    launches = 0;
    while (resp_valid !== 1'b1 && n < 3000) begin
      tick();
      n++;
      if (mdu_valid === 1'b1) launches++;
    end
    check("resp_latency", n, hang ? TMO + 1 : lat + 1);
    check("no_relaunch", launches, 0);
    check("resp_id", resp_id, pick);
    check("resp_result", resp_result, e[P-1:0]);
    check("resp_flags", {resp_div_overflow, resp_div_by_zero, resp_timeout}, {e[P+1], e[P], eto});
    check("ops_held", {mdu_lop, mdu_rop}, {lop_a[pick], rop_a[pick]});
    for (int k = 0; k < bp; k++) begin
      tick();
      check("bp_hold", {resp_valid, resp_id, resp_result}, {1'b1, 1'(pick), e[P-1:0]});
      check("bp_no_accept", req_ready, 0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("resp_drop", resp_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; resp_ready = 1'b0;
    req_op_code = '0; req_lop = '0; req_rop = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = 3'd0; lop_a[i] = 32'd0; rop_a[i] = 32'd0;
    end
    do_reset();

    // Single request: 7*6 with done five cycles after launch.
    op_a[0] = 3'b000; lop_a[0] = 32'd7; rop_a[0] = 32'd6;
    transact(2'b01, 5, 0, 1'b0);

    // Contention from reset: 0 then 1, then both again gives 0 then 1.
    do_reset();
    op_a[0] = 3'b001; lop_a[0] = 32'd10; rop_a[0] = 32'd20;
    op_a[1] = 3'b000; lop_a[1] = 32'd3;  rop_a[1] = 32'd9;
    transact(2'b11, 2, 0, 1'b0);
    transact(2'b00, 2, 0, 1'b0);
    lop_a[0] = 32'd11; lop_a[1] = 32'd5;
    transact(2'b11, 3, 0, 1'b0);
    transact(2'b00, 1, 0, 1'b0);

    // Back-pressure with the other requester pending.
    lop_a[0] = 32'h1234; lop_a[1] = 32'h55;
    transact(2'b11, 3, 4, 1'b0);
    transact(2'b00, 2, 0, 1'b0);

    // Divide by zero flag passthrough.
    op_a[0] = 3'b100; lop_a[0] = 32'd99; rop_a[0] = 32'd0;
    transact(2'b01, 4, 1, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 24; t++) begin
      logic [N-1:0] add;
      add = N'($urandom_range(0, 3)) & ~req_valid;
      if ((add | req_valid) == '0) add[0] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (add[i]) begin
          op_a[i]  = 3'($urandom);
          lop_a[i] = $urandom;
          rop_a[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
          if ($urandom_range(0, 4) == 0) begin
            op_a[i] = 3'b111; lop_a[i] = 32'h8000_0000; rop_a[i] = 32'hFFFF_FFFF;
          end
        end
      end
      transact(add, $urandom_range(1, 6), $urandom_range(0, 2), 1'b0);
    end
    while (req_valid != '0) transact('0, 2, 0, 1'b0);

    // Reset three cycles after launch: no response, late done ignored.
    op_a[1] = 3'b001; lop_a[1] = 32'd100; rop_a[1] = 32'd23;
    unit_lat = 10; unit_hang = 1'b0;
    req_valid = 2'b10;
    drive_data();
    #1;
    check("mw_ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    check("mw_launch", mdu_valid, 1);
    tick(); tick(); tick();
    do_reset();
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 14; k++) begin
        tick();
        if (resp_valid !== 1'b0 || busy !== 1'b0) seen++;
      end
      check("mw_no_resp", seen, 0);
    end
    lop_a[1] = 32'd77; rop_a[1] = 32'd1;
    transact(2'b10, 3, 0, 1'b0);

    // Watchdog: unit never completes.
    op_a[0] = 3'b000; lop_a[0] = 32'd5; rop_a[0] = 32'd5;
    transact(2'b01, 1, 1, 1'b1);
    check("fault_set", {fault, busy}, 2'b11);
    req_valid = 2'b11;
    drive_data();
    begin
      int leaks;
      leaks = 0;
      for (int k = 0; k < 6; k++) begin
        #1;
        if (req_ready !== '0 || mdu_valid !== 1'b0 || resp_valid !== 1'b0) leaks++;
        if (k == 2) stray = 1'b1;
        tick();
      end
      check("fault_quiet", leaks, 0);
    end
    check("fault_sticky", fault, 1);
    do_reset();
    check("fault_cleared", {fault, busy}, 0);
    unit_hang = 1'b0;
    op_a[0] = 3'b001; lop_a[0] = 32'd40; rop_a[0] = 32'd2;
    transact(2'b01, 2, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
